mux8_rr_sequencer: RTL and testbench

Round-robin sequencer for the team's 8:1 strobed multiplexer (data inputs a..h, select i/j/k, active-low strobe l). Eight requesters share the mux output. The block arbitrates among them and drives the 3-bit select and the strobe. It guarantees break-before-make: the select never changes while the strobe is active.

---
 rtl/mux8_rr_sequencer.sv | 134 +++++++++++++
 tb/tb_mux8_rr_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_sequencer.sv
// mux8_rr_sequencer: round-robin arbiter that drives the select and strobe of an 8:1 strobed mux, with break-before-make.
// Define MUX8_RR_TIMEOUT_EN to add the HOLD_MAX grant timeout; the default build holds a grant until done or req drops.
module mux8_rr_sequencer #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [2:0] sel,
   output logic       en_n,
   output logic [7:0] gnt,
   output logic       busy,
   output logic       timeout
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SETUP   = 2'd1;
   localparam logic [1:0] ST_ACTIVE  = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   if ((HOLD_MAX == 0) || (HOLD_MAX > 255)) begin : g_bad_hold_max
      $error("mux8_rr_sequencer: HOLD_MAX must be in 1..255");
   end

   logic [1:0] state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] sel_q, sel_d;
   logic       en_n_q, en_n_d;
   logic [7:0] gnt_q, gnt_d;
   logic       busy_q, busy_d;
   logic       timeout_q, timeout_d;
   logic [2:0] winner;
   logic       expire;

   // First requester at or above p, wrapping 7 -> 0; the smallest offset wins.
   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] idx;
      rr_pick = p;
      for (int k = 7; k >= 0; k--) begin
         idx = p + 3'(k);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   assign winner = rr_pick(req, ptr_q);

`ifdef MUX8_RR_TIMEOUT_EN
   logic [7:0] hold_q, hold_d;

   // hold_q counts ACTIVE cycles already completed, so the HOLD_MAX-th ACTIVE cycle sees HOLD_MAX-1.
   always_comb begin
      hold_d = 8'd0;
      if (state_q == ST_ACTIVE) hold_d = hold_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_q <= 8'd0;
      else        hold_q <= hold_d;
   end

   assign expire = (hold_q == 8'(HOLD_MAX - 1));
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path through the case leaves it unassigned (no latch).
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      en_n_d    = en_n_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_RELEASE: begin
            en_n_d = 1'b1;
            gnt_d  = 8'h00;
            busy_d = 1'b0;
            state_d = ST_IDLE;
            if (req != 8'h00) begin
               // sel only moves here, while the strobe is already inactive.
               state_d = ST_SETUP;
               sel_d   = winner;
               gnt_d   = 8'b1 << winner;
               busy_d  = 1'b1;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACTIVE;
            en_n_d  = 1'b0;
         end
         ST_ACTIVE: begin
            if (done || !req[sel_q] || expire) begin
               state_d   = ST_RELEASE;
               en_n_d    = 1'b1;
               gnt_d     = 8'h00;
               ptr_d     = sel_q + 3'd1;
               timeout_d = !done && req[sel_q];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 3'd0;
         sel_q     <= 3'd0;
         en_n_q    <= 1'b1;
         gnt_q     <= 8'h00;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         sel_q     <= sel_d;
         en_n_q    <= en_n_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign sel     = sel_q;
   assign en_n    = en_n_q;
   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_mux8_rr_sequencer.sv
// Self-checking bench for mux8_rr_sequencer: directed scenarios plus randomized traffic against a grant-level model.
// Builds with or without MUX8_RR_TIMEOUT_EN; the DUT is instantiated with HOLD_MAX = 4.
module tb_mux8_rr_sequencer;

   localparam int HOLD = 4;
`ifdef MUX8_RR_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [2:0] sel;
   logic       en_n;
   logic [7:0] gnt;
   logic       busy;
   logic       timeout;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mux8_rr_sequencer #(.HOLD_MAX(HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .sel     (sel),
      .en_n    (en_n),
      .gnt     (gnt),
      .busy    (busy),
      .timeout (timeout)
   );

   // Grant-level model: owner of the current grant, how many strobe cycles it has had, and whether it is being released.
   int m_ptr, m_owner, m_age, m_sel;
   bit m_rel, m_to;

   task automatic model_reset();
      m_ptr = 0; m_owner = -1; m_age = 0; m_sel = 0; m_rel = 1'b0; m_to = 1'b0;
   endtask

   function automatic int rr_winner(input logic [7:0] r, input int p);
      for (int k = 0; k < 8; k++)
         if (r[(p + k) % 8]) return (p + k) % 8;
      return -1;
   endfunction

   task automatic model_edge(input logic [7:0] r, input logic d);
      if (m_owner >= 0 && !m_rel) begin
         if (m_age == 0) m_age = 1;
         else if (d || !r[m_owner]) begin
            m_rel = 1'b1; m_to = 1'b0; m_ptr = (m_owner + 1) % 8;
         end else if (TO_EN && m_age == HOLD) begin
            m_rel = 1'b1; m_to = 1'b1; m_ptr = (m_owner + 1) % 8;
         end else m_age++;
      end else begin
         m_rel = 1'b0; m_to = 1'b0;
         m_owner = rr_winner(r, m_ptr);
         if (m_owner >= 0) begin
            m_sel = m_owner;
            m_age = 0;
         end
      end
   endtask

   // Expected {sel, en_n, gnt, busy, timeout}.
   function automatic logic [13:0] model_out();
      bit granted;
      logic [7:0] g;
      granted = (m_owner >= 0) && !m_rel;
      g = granted ? 8'(1 << m_owner) : 8'h00;
      return {3'(m_sel), !(granted && m_age >= 1), g, (m_owner >= 0), m_to};
   endfunction

   task automatic step(input logic [7:0] r, input logic d);
      req = r; done = d;
      @(posedge clk);
      model_edge(r, d);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      req = 8'h00; done = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic go_idle();
      for (int i = 0; i < 4 && m_owner >= 0; i++) step(8'h00, 1'b0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({sel, en_n, gnt, busy, timeout} !== {3'd0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL reset_por: got %h want %h", {sel, en_n, gnt, busy, timeout}, {3'd0, 1'b1, 8'h00, 1'b0, 1'b0});
      end
      rst_n = 1'b1;
      model_reset();
      step(8'h20, 1'b0);
      n_cmp++;
      if (sel !== 3'd5 || gnt !== 8'h20) begin
         n_bad++; $display("FAIL reset_pre_setup: sel %0d gnt %h want 5 20", sel, gnt);
      end
      step(8'h20, 1'b0);
      n_cmp++;
      if (en_n !== 1'b0) begin
         n_bad++; $display("FAIL reset_pre_active: en_n %b want 0", en_n);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({sel, en_n, gnt, busy, timeout} !== {3'd0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL reset_async: got %h want %h", {sel, en_n, gnt, busy, timeout}, {3'd0, 1'b1, 8'h00, 1'b0, 1'b0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(8'hFF, 1'b0);
      n_cmp++;
      if (sel !== 3'd0 || gnt !== 8'h01 || en_n !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL reset_first_grant: sel %0d gnt %h en_n %b busy %b want 0 01 1 1", sel, gnt, en_n, busy);
      end
      go_idle();
   endtask

   task automatic test_single();
      step(8'h04, 1'b0);
      n_cmp++;
      if (sel !== 3'd2 || gnt !== 8'h04 || en_n !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL single_setup: sel %0d gnt %h en_n %b busy %b want 2 04 1 1", sel, gnt, en_n, busy);
      end
      step(8'h04, 1'b0);
      n_cmp++;
      if (en_n !== 1'b0 || gnt !== 8'h04) begin
         n_bad++; $display("FAIL single_active: en_n %b gnt %h want 0 04", en_n, gnt);
      end
      step(8'h04, 1'b1);
      n_cmp++;
      if (en_n !== 1'b1 || gnt !== 8'h00 || busy !== 1'b1 || sel !== 3'd2 || timeout !== 1'b0) begin
         n_bad++; $display("FAIL single_release: en_n %b gnt %h busy %b sel %0d to %b want 1 00 1 2 0", en_n, gnt, busy, sel, timeout);
      end
      step(8'h00, 1'b0);
      n_cmp++;
      if (busy !== 1'b0 || en_n !== 1'b1 || sel !== 3'd2) begin
         n_bad++; $display("FAIL single_idle: busy %b en_n %b sel %0d want 0 1 2", busy, en_n, sel);
      end
   endtask

   task automatic test_rotation();
      int hi_run;
      apply_reset();
      hi_run = 0;
      for (int g = 0; g < 9; g++) begin
         step(8'hFF, 1'b0);
         n_cmp++;
         if (sel !== 3'(g % 8) || gnt !== 8'(1 << (g % 8))) begin
            n_bad++; $display("FAIL rotation_grant%0d: sel %0d gnt %h want %0d %h", g, sel, gnt, g % 8, 8'(1 << (g % 8)));
         end
         hi_run += en_n ? 1 : 0;
         step(8'hFF, 1'b0);
         n_cmp++;
         if (en_n !== 1'b0 || (g > 0 && hi_run != 2)) begin
            n_bad++; $display("FAIL rotation_gap%0d: en_n %b gap %0d want 0 2", g, en_n, hi_run);
         end
         hi_run = 0;
         step(8'hFF, 1'b1);
         hi_run += en_n ? 1 : 0;
      end
      go_idle();
   endtask

   task automatic test_wrap();
      apply_reset();
      step(8'h80, 1'b0);
      n_cmp++;
      if (sel !== 3'd7) begin
         n_bad++; $display("FAIL wrap_first: sel %0d want 7", sel);
      end
      step(8'h81, 1'b0);
      step(8'h81, 1'b1);
      step(8'h81, 1'b0);
      n_cmp++;
      if (sel !== 3'd0 || gnt !== 8'h01) begin
         n_bad++; $display("FAIL wrap_to_a: sel %0d gnt %h want 0 01", sel, gnt);
      end
      step(8'h81, 1'b0);
      step(8'h81, 1'b1);
      step(8'h81, 1'b0);
      n_cmp++;
      if (sel !== 3'd7 || gnt !== 8'h80) begin
         n_bad++; $display("FAIL wrap_back_h: sel %0d gnt %h want 7 80", sel, gnt);
      end
      go_idle();
   endtask

   task automatic test_req_drop();
      step(8'h10, 1'b0);
      step(8'h10, 1'b0);
      step(8'h00, 1'b0);
      n_cmp++;
      if (en_n !== 1'b1 || gnt !== 8'h00 || busy !== 1'b1 || timeout !== 1'b0) begin
         n_bad++; $display("FAIL drop_release: en_n %b gnt %h busy %b to %b want 1 00 1 0", en_n, gnt, busy, timeout);
      end
      step(8'h00, 1'b0);
      n_cmp++;
      if (busy !== 1'b0 || timeout !== 1'b0) begin
         n_bad++; $display("FAIL drop_idle: busy %b to %b want 0 0", busy, timeout);
      end
      step(8'h10, 1'b0);
      step(8'h00, 1'b0);
      n_cmp++;
      if (en_n !== 1'b0 || gnt !== 8'h10) begin
         n_bad++; $display("FAIL withdrawn_active: en_n %b gnt %h want 0 10", en_n, gnt);
      end
      step(8'h00, 1'b0);
      n_cmp++;
      if (en_n !== 1'b1 || gnt !== 8'h00) begin
         n_bad++; $display("FAIL withdrawn_release: en_n %b gnt %h want 1 00", en_n, gnt);
      end
      go_idle();
   endtask

`ifdef MUX8_RR_TIMEOUT_EN
   task automatic test_timeout();
      int low, tos;
      logic [7:0] next_g;
      apply_reset();
      low = 0; tos = 0; next_g = 8'h00;
      step(8'h03, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(8'h03, 1'b0);
         if (!en_n) low++;
         if (timeout) begin
            tos++;
            n_cmp++;
            if (en_n !== 1'b1 || gnt !== 8'h00) begin
               n_bad++; $display("FAIL timeout_in_release: en_n %b gnt %h want 1 00", en_n, gnt);
            end
         end
         if (tos > 0 && gnt != 8'h00) begin
            next_g = gnt;
            break;
         end
      end
      n_cmp++;
      if (low != HOLD || tos != 1 || next_g !== 8'h02) begin
         n_bad++; $display("FAIL timeout_hold: active %0d pulses %0d next %h want %0d 1 02", low, tos, next_g, HOLD);
      end
      go_idle();
      apply_reset();
      step(8'h01, 1'b0);
      for (int i = 0; i < HOLD; i++) step(8'h01, 1'b0);
      step(8'h01, 1'b1);
      n_cmp++;
      if (timeout !== 1'b0 || en_n !== 1'b1) begin
         n_bad++; $display("FAIL timeout_done_same_edge: to %b en_n %b want 0 1", timeout, en_n);
      end
      go_idle();
   endtask
`else
   task automatic test_timeout();
      int low, tos, bad_g;
      apply_reset();
      low = 0; tos = 0; bad_g = 0;
      step(8'h03, 1'b0);
      for (int i = 0; i < 110; i++) begin
         step(8'h03, 1'b0);
         if (!en_n) low++;
         if (timeout) tos++;
         if (gnt !== 8'h01) bad_g++;
      end
      n_cmp++;
      if (low != 110 || tos != 0 || bad_g != 0) begin
         n_bad++; $display("FAIL no_timeout_hold: active %0d pulses %0d wrong_gnt %0d want 110 0 0", low, tos, bad_g);
      end
      go_idle();
   endtask
`endif

   task automatic test_random();
      logic [7:0] r;
      logic       d;
      logic [2:0] prev_sel;
      logic       prev_en_n;
      apply_reset();
      r = 8'h00;
      prev_sel = sel;
      prev_en_n = en_n;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         d = ($urandom_range(0, 3) == 0);
         step(r, d);
         n_cmp++;
         if ({sel, en_n, gnt, busy, timeout} !== model_out()) begin
            n_bad++; $display("FAIL random_cycle%0d: got %h want %h (req %h done %b)", c, {sel, en_n, gnt, busy, timeout}, model_out(), r, d);
         end
         n_cmp++;
         if (prev_en_n === 1'b0 && sel !== prev_sel) begin
            n_bad++; $display("FAIL break_before_make%0d: sel %0d changed from %0d while strobe active", c, sel, prev_sel);
         end
         prev_sel = sel;
         prev_en_n = en_n;
      end
      go_idle();
   endtask

   initial begin
      rst_n = 1'b0;
      req = 8'h00;
      done = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_req_drop();
      test_timeout();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
